// File: rtl/button_ctrl_if.sv
// Button/display handshake bundle between the front-panel debouncer, the
// button sequencer and the CPU-reset / display-clear logic.
interface button_ctrl_if;
   logic btn_reset;
   logic btn_clr;
   logic clr_ack;
   logic sys_reset_out;
   logic clr_req;
   logic clr_fail;
   logic busy;
   logic sample_tick;

   // master drives the buttons and the display ack; slave is the sequencer
   modport master (
      output btn_reset, btn_clr, clr_ack,
      input  sys_reset_out, clr_req, clr_fail, busy, sample_tick
   );
   modport slave (
      input  btn_reset, btn_clr, clr_ack,
      output sys_reset_out, clr_req, clr_fail, busy, sample_tick
   );
endinterface

// File: rtl/button_ctrl.sv
// Front-panel button sequencer: RESET press -> fixed reset pulse, CLEAR press ->
// req/ack handshake with timeout, RESET has priority; plus a free-running sample tick.
module button_ctrl #(
   parameter int RST_PULSE_CYCLES = 16,
   parameter int CLR_TIMEOUT      = 255,
   parameter int TICK_DIV         = 1000
) (
   input logic         clk,
   input logic         rst,
   button_ctrl_if.slave bus
);
   localparam int CMAX = (RST_PULSE_CYCLES > CLR_TIMEOUT) ? RST_PULSE_CYCLES : CLR_TIMEOUT;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int DW   = $clog2(TICK_DIV);

   typedef enum logic [1:0] {IDLE, RST_HOLD, CLR_REQ} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [DW-1:0] div;
   logic          prev_rst, prev_clr;
   logic          press_rst, press_clr;

   assign press_rst = bus.btn_reset & ~prev_rst;
   assign press_clr = bus.btn_clr & ~prev_clr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= IDLE;
         cnt               <= '0;
         div               <= '0;
         // history starts "pressed" so a button held through reset cannot fire
         prev_rst          <= 1'b1;
         prev_clr          <= 1'b1;
         bus.sys_reset_out <= 1'b0;
         bus.clr_req       <= 1'b0;
         bus.clr_fail      <= 1'b0;
         bus.busy          <= 1'b0;
         bus.sample_tick   <= 1'b0;
      end else begin
         prev_rst     <= bus.btn_reset;
         prev_clr     <= bus.btn_clr;
         bus.clr_fail <= 1'b0;

         // tick is registered one count early so it lines up with div == TICK_DIV-1
         div             <= (div == DW'(TICK_DIV - 1)) ? '0 : div + DW'(1);
         bus.sample_tick <= (div == DW'(TICK_DIV - 2));

         case (state)
            IDLE: begin
               if (press_rst) begin
                  state             <= RST_HOLD;
                  cnt               <= CW'(RST_PULSE_CYCLES - 1);
                  bus.sys_reset_out <= 1'b1;
                  bus.busy          <= 1'b1;
               end else if (press_clr) begin
                  state       <= CLR_REQ;
                  cnt         <= CW'(CLR_TIMEOUT - 1);
                  bus.clr_req <= 1'b1;
                  bus.busy    <= 1'b1;
               end
            end
            RST_HOLD: begin
               if (cnt == '0) begin
                  state             <= IDLE;
                  bus.sys_reset_out <= 1'b0;
                  bus.busy          <= 1'b0;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            CLR_REQ: begin
               if (press_rst) begin
                  state             <= RST_HOLD;
                  cnt               <= CW'(RST_PULSE_CYCLES - 1);
                  bus.clr_req       <= 1'b0;
                  bus.sys_reset_out <= 1'b1;
               end else if (bus.clr_ack) begin
                  state       <= IDLE;
                  bus.clr_req <= 1'b0;
                  bus.busy    <= 1'b0;
               end else if (cnt == '0) begin
                  state        <= IDLE;
                  bus.clr_req  <= 1'b0;
                  bus.clr_fail <= 1'b1;
                  bus.busy     <= 1'b0;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: begin
               state             <= IDLE;
               bus.sys_reset_out <= 1'b0;
               bus.clr_req       <= 1'b0;
               bus.busy          <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_button_ctrl.sv
// Directed bench for button_ctrl: a cycle model of the button rules is compared
// against every output each cycle, with literal pulse-length checks on top.
module tb_button_ctrl;
   localparam int RP = 16;
   localparam int CT = 255;
   localparam int TD = 7;

   logic clk = 1'b0;
   logic rst = 1'b1;

   button_ctrl_if bus();

   button_ctrl #(.RST_PULSE_CYCLES(RP), .CLR_TIMEOUT(CT), .TICK_DIV(TD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // model state: reset-pulse cycles left, clear request outstanding and its age
   int m_rleft = 0;
   bit m_creq  = 0;
   int m_cage  = 0;
   bit m_fail  = 0;
   bit m_pr    = 1;
   bit m_pc    = 1;
   int m_edges = 0;

   always @(posedge clk) begin
      bit pr, pc;
      if (rst) begin
         m_rleft = 0; m_creq = 0; m_cage = 0; m_fail = 0;
         m_pr = 1; m_pc = 1; m_edges = 0;
      end else begin
         pr = bus.btn_reset && !m_pr;
         pc = bus.btn_clr && !m_pc;
         m_pr = bus.btn_reset;
         m_pc = bus.btn_clr;
         m_fail = 0;
         m_edges++;
         if (m_rleft > 0) m_rleft--;
         else if (m_creq) begin
            if (pr) begin m_creq = 0; m_rleft = RP; end
            else if (bus.clr_ack) m_creq = 0;
            else if (m_cage == CT) begin m_creq = 0; m_fail = 1; end
            else m_cage++;
         end else if (pr) m_rleft = RP;
         else if (pc) begin m_creq = 1; m_cage = 1; end
      end
   end

   int n_rst_hi = 0, n_clr_hi = 0, n_fail = 0, n_tick = 0;
   int cyc = 0, last_tick = -1;
   bit armed = 0;

   always @(negedge clk) begin
      if (armed) begin
         check("sys_reset_out", int'(bus.sys_reset_out), int'(m_rleft > 0));
         check("clr_req",       int'(bus.clr_req),       int'(m_creq));
         check("clr_fail",      int'(bus.clr_fail),      int'(m_fail));
         check("busy",          int'(bus.busy),          int'((m_rleft > 0) || m_creq));
         check("sample_tick",   int'(bus.sample_tick),   int'((m_edges % TD) == TD - 1));
      end
      if (bus.sys_reset_out === 1'b1) n_rst_hi++;
      if (bus.clr_req === 1'b1)       n_clr_hi++;
      if (bus.clr_fail === 1'b1)      n_fail++;
      if (rst) last_tick = -1;
      else if (bus.sample_tick === 1'b1) begin
         n_tick++;
         if (last_tick >= 0) check("tick_period", cyc - last_tick, TD);
         last_tick = cyc;
      end
      cyc++;
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_counts();
      n_rst_hi = 0; n_clr_hi = 0; n_fail = 0; n_tick = 0;
   endtask

   initial begin
      bus.btn_reset = 0; bus.btn_clr = 0; bus.clr_ack = 0;

      // 1: reset then idle
      step(3);
      armed = 1;
      check("reset_sro",  int'(bus.sys_reset_out), 0);
      check("reset_req",  int'(bus.clr_req), 0);
      check("reset_busy", int'(bus.busy), 0);
      check("reset_tick", int'(bus.sample_tick), 0);
      rst = 0;
      clear_counts();
      step(20);
      check("idle_ticks", n_tick, 20 / TD);
      check("idle_rst_hi", n_rst_hi, 0);

      // 2: RESET held 50 cycles -> one 16-cycle pulse
      clear_counts();
      bus.btn_reset = 1;
      step(1);
      check("pulse_start", int'(bus.sys_reset_out), 1);
      step(49);
      bus.btn_reset = 0;
      step(5);
      check("pulse_len", n_rst_hi, RP);

      // 3: CLEAR press, ack raised after 5 more cycles
      clear_counts();
      bus.btn_clr = 1;
      step(1);
      bus.btn_clr = 0;
      step(5);
      bus.clr_ack = 1;
      step(1);
      check("ack_req_dropped", int'(bus.clr_req), 0);
      bus.clr_ack = 0;
      step(3);
      check("ack_req_len", n_clr_hi, 6);
      check("ack_no_fail", n_fail, 0);

      // 4: CLEAR press, no ack -> timeout
      clear_counts();
      bus.btn_clr = 1;
      step(1);
      bus.btn_clr = 0;
      step(CT + 5);
      check("to_req_len", n_clr_hi, CT);
      check("to_fail_cnt", n_fail, 1);
      check("to_busy", int'(bus.busy), 0);

      // 5: CLEAR then RESET 3 cycles later
      clear_counts();
      bus.btn_clr = 1;
      step(1);
      bus.btn_clr = 0;
      step(2);
      bus.btn_reset = 1;
      step(1);
      check("pre_req", int'(bus.clr_req), 0);
      check("pre_sro", int'(bus.sys_reset_out), 1);
      bus.btn_reset = 0;
      step(25);
      check("pre_req_len", n_clr_hi, 3);
      check("pre_pulse_len", n_rst_hi, RP);
      check("pre_no_fail", n_fail, 0);

      // 6: RESET held through rst release, then mid-pulse rst
      bus.btn_reset = 1;
      rst = 1;
      step(2);
      rst = 0;
      clear_counts();
      step(20);
      check("held_no_pulse", n_rst_hi, 0);
      bus.btn_reset = 0;
      step(1);
      bus.btn_reset = 1;
      step(30);
      check("repress_len", n_rst_hi, RP);
      bus.btn_reset = 0;
      step(2);
      bus.btn_reset = 1;
      step(5);
      check("mid_pulse_on", int'(bus.sys_reset_out), 1);
      rst = 1;
      step(1);
      check("mid_rst_sro", int'(bus.sys_reset_out), 0);
      check("mid_rst_busy", int'(bus.busy), 0);
      rst = 0;
      clear_counts();
      step(25);
      check("mid_rst_no_refire", n_rst_hi, 0);
      bus.btn_reset = 0;

      // ack outside CLR_REQ and simultaneous presses
      bus.clr_ack = 1;
      step(3);
      check("stray_ack_busy", int'(bus.busy), 0);
      bus.clr_ack = 0;
      clear_counts();
      bus.btn_reset = 1; bus.btn_clr = 1;
      step(1);
      bus.btn_reset = 0; bus.btn_clr = 0;
      step(20);
      check("both_pulse", n_rst_hi, RP);
      check("both_no_req", n_clr_hi, 0);

      step(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
